// File: rtl/packet_gen_if.sv
// AXI4-Stream transmit bundle between a packet generator and its Ethernet port.
interface packet_gen_if #(
    parameter int DATA_WBITS = 512
);
    logic [DATA_WBITS-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/packet_gen.sv
// Cable-test packet transmitter: emits a numbered stream of fixed-length
// packets on an AXI4-Stream master, with halt and single-bit error injection.
module packet_gen #(
    parameter int DATA_WBITS = 512    // multiple of 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        pg_control,
    output logic [2:0]        pg_status,
    input  logic [7:0]        CYCLES_PER_PACKET,
    input  logic [63:0]       PACKET_COUNT,
    packet_gen_if.master      axis_tx
);
    localparam int LANES = DATA_WBITS / 64;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]            state;
    logic [8:0]            cpp;            // 1..256 beats per packet
    logic [63:0]           remaining;
    logic [63:0]           seq;            // seq of the beat currently on the bus
    logic [7:0]            beat_cnt;       // index of that beat inside its packet
    logic                  halt_pending;
    logic                  inject_pending;
    logic                  sent;
    logic                  halted;
    logic [DATA_WBITS-1:0] tdata_q;
    logic                  tlast_q;

    logic                  start_s;
    logic                  halt_s;
    logic                  inject_s;
    logic                  accept;
    logic                  pkt_done;
    logic                  stop_run;
    logic                  inject_now;
    logic [63:0]           seq_next;
    logic [63:0]           remaining_next;
    logic [7:0]            beat_next;

    // Builds one beat: seq in every 64-bit lane, optional bit-0 corruption.
    function automatic logic [DATA_WBITS-1:0] make_beat(input logic [63:0] s,
                                                        input logic flip);
        logic [DATA_WBITS-1:0] d;
        for (int l = 0; l < LANES; l++) begin
            d[l*64 +: 64] = s;
        end
        d[0] = d[0] ^ flip;
        return d;
    endfunction

    // Strobe decode and next-beat arithmetic.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        start_s        = pg_control[0];
        halt_s         = pg_control[1];
        inject_s       = pg_control[2];
        accept         = (state == ST_SEND) && axis_tx.tready;
        pkt_done       = accept && tlast_q;
        remaining_next = remaining - 64'd1;
        // A halt strobe arriving with the TLAST handshake stops after this packet.
        stop_run       = pkt_done && ((remaining_next == 64'd0) || halt_pending || halt_s);
        seq_next       = seq + 64'd1;
        beat_next      = tlast_q ? 8'd0 : beat_cnt + 8'd1;
        // An inject seen in the same cycle as a load corrupts that load.
        inject_now     = inject_pending || inject_s;
    end

    // Run control, counters and the registered AXIS output stage.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cpp            <= 9'd0;
            remaining      <= 64'd0;
            seq            <= 64'd0;
            beat_cnt       <= 8'd0;
            halt_pending   <= 1'b0;
            inject_pending <= 1'b0;
            sent           <= 1'b0;
            halted         <= 1'b0;
            tdata_q        <= '0;
            tlast_q        <= 1'b0;
        end else begin
            sent <= pkt_done;
            case (state)
                ST_IDLE: begin
                    // Halt and inject are meaningless without a run and are dropped.
                    if (start_s && (PACKET_COUNT != 64'd0)) begin
                        state          <= ST_SEND;
                        cpp            <= (CYCLES_PER_PACKET == 8'd0) ? 9'd256
                                                                      : {1'b0, CYCLES_PER_PACKET};
                        remaining      <= PACKET_COUNT;
                        seq            <= 64'd0;
                        beat_cnt       <= 8'd0;
                        halted         <= 1'b0;
                        halt_pending   <= 1'b0;
                        inject_pending <= 1'b0;
                        tdata_q        <= make_beat(64'd0, 1'b0);
                        tlast_q        <= (CYCLES_PER_PACKET == 8'd1);
                    end
                end
                ST_SEND: begin
                    if (halt_s) begin
                        halt_pending <= 1'b1;
                    end
                    if (inject_s) begin
                        inject_pending <= 1'b1;
                    end
                    if (pkt_done) begin
                        remaining <= remaining_next;
                    end
                    if (stop_run) begin
                        state          <= ST_IDLE;
                        halted         <= halt_pending || halt_s;
                        halt_pending   <= 1'b0;
                        inject_pending <= 1'b0;
                        tdata_q        <= '0;
                        tlast_q        <= 1'b0;
                    end else if (accept) begin
                        // Packets run back to back: the next beat loads on every handshake.
                        seq            <= seq_next;
                        beat_cnt       <= beat_next;
                        tdata_q        <= make_beat(seq_next, inject_now);
                        tlast_q        <= ({1'b0, beat_next} == (cpp - 9'd1));
                        inject_pending <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign axis_tx.tvalid = (state == ST_SEND);
    assign axis_tx.tdata  = tdata_q;
    assign axis_tx.tlast  = tlast_q;
    assign pg_status      = {halted, sent, (state == ST_SEND)};
endmodule

// File: tb/tb_packet_gen.sv
// Self-checking bench for packet_gen: table of runs plus a reset sequence,
// with a scoreboard of expected beats consumed by a negedge monitor.
module tb_packet_gen;
    localparam int W     = 512;
    localparam int LANES = W / 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  pg_control;
    logic [2:0]  pg_status;
    logic [7:0]  cpp_in;
    logic [63:0] count_in;

    packet_gen_if #(.DATA_WBITS(W)) axis_tx ();

    packet_gen #(.DATA_WBITS(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .pg_control        (pg_control),
        .pg_status         (pg_status),
        .CYCLES_PER_PACKET (cpp_in),
        .PACKET_COUNT      (count_in),
        .axis_tx           (axis_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint unsigned seq;
        bit              last;
        bit              corrupt;
    } beat_t;

    typedef struct {
        int cpp;
        int count;
        int rmode;       // 0: TREADY=1, 1: random TREADY
        int halt_at;     // halt while this beat is on the bus, -1 none
        int inj_at;      // first inject while this beat is on the bus, -1 none
        int inj_len;     // consecutive inject cycles
        int inj_stall;   // hold TREADY low while injecting
        int restart_at;  // extra start while this beat is on the bus, -1 none
        int exp_beats;
        int exp_sent;
        int exp_halted;
        int exp_busy;    // -1: not checked
    } vec_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    accepted = 0;
    int    sent_cnt = 0;
    int    busy_cycles = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] beat_data(input longint unsigned s, input bit flip);
        logic [W-1:0] d;
        for (int l = 0; l < LANES; l++) begin
            d[l*64 +: 64] = 64'(s);
        end
        d[0] = d[0] ^ flip;
        return d;
    endfunction

    // Monitor: scoreboard pops, stall stability and sent alignment.
    initial begin
        logic         prev_valid = 1'b0;
        logic         prev_ready = 1'b0;
        logic         prev_last  = 1'b0;
        logic         prev_reset = 1'b1;
        logic [W-1:0] prev_data  = '0;
        beat_t        e;
        forever begin
            @(negedge clk);
            if (!reset && !prev_reset) begin
                if (prev_valid && !prev_ready) begin
                    check("stall_tvalid", W'(axis_tx.tvalid), W'(1));
                    check("stall_tdata", axis_tx.tdata, prev_data);
                    check("stall_tlast", W'(axis_tx.tlast), W'(prev_last));
                end
                check("sent_align", W'(pg_status[1]), W'(prev_valid & prev_ready & prev_last));
            end
            if (!reset && axis_tx.tvalid && axis_tx.tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", W'(accepted), W'(-1));
                end else begin
                    e = sb.pop_front();
                    check("beat_tdata", axis_tx.tdata, beat_data(e.seq, e.corrupt));
                    check("beat_tlast", W'(axis_tx.tlast), W'(e.last));
                end
                accepted++;
            end
            if (pg_status[0]) busy_cycles++;
            if (pg_status[1]) sent_cnt++;
            prev_valid = axis_tx.tvalid;
            prev_ready = axis_tx.tready;
            prev_last  = axis_tx.tlast;
            prev_data  = axis_tx.tdata;
            prev_reset = reset;
        end
    end

    task automatic push_beats(input int n, input int cpe, input int c_lo, input int c_hi);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.seq     = longint'(i);
            e.last    = ((i % cpe) == cpe - 1);
            e.corrupt = (i >= c_lo) && (i <= c_hi);
            sb.push_back(e);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cpe;
        int inj_left;
        bit done;
        bit inj_started;
        bit halt_done;
        bit restart_done;
        int c_lo;
        int c_hi;
        cpe = (v.cpp == 0) ? 256 : v.cpp;
        c_lo = -1;
        c_hi = -2;
        if (v.inj_len > 0) begin
            c_lo = v.inj_at + 1;
            c_hi = (v.inj_stall != 0) ? c_lo : v.inj_at + v.inj_len;
        end
        push_beats(v.exp_beats, cpe, c_lo, c_hi);
        accepted = 0;
        sent_cnt = 0;
        busy_cycles = 0;
        inj_left = 0;
        inj_started = 0;
        halt_done = 0;
        restart_done = 0;
        done = 0;

        @(posedge clk); #1;
        cpp_in     = 8'(v.cpp);
        count_in   = 64'(v.count);
        pg_control = 3'b001;
        axis_tx.tready = (v.rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk); #1;
            pg_control = 3'b000;
            axis_tx.tready = (v.rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!pg_status[0]) begin
                done = 1;
                break;
            end
            if (!inj_started && v.inj_len > 0 && accepted == v.inj_at) begin
                inj_started = 1;
                inj_left = v.inj_len;
            end
            if (inj_left > 0) begin
                pg_control[2] = 1'b1;
                if (v.inj_stall != 0) axis_tx.tready = 1'b0;
                inj_left--;
            end
            if (!halt_done && v.halt_at >= 0 && accepted == v.halt_at) begin
                pg_control[1] = 1'b1;
                halt_done = 1;
            end
            if (!restart_done && v.restart_at >= 0 && accepted == v.restart_at) begin
                pg_control[0] = 1'b1;
                cpp_in   = 8'd2;
                count_in = 64'd50;
                restart_done = 1;
            end
        end
        if (!done) check({tag, "_timeout"}, W'(0), W'(1));
        axis_tx.tready = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_beats"}, W'(accepted), W'(v.exp_beats));
        check({tag, "_sent"}, W'(sent_cnt), W'(v.exp_sent));
        check({tag, "_halted"}, W'(pg_status[2]), W'(v.exp_halted));
        check({tag, "_sb_empty"}, W'(sb.size()), W'(0));
        if (v.exp_busy >= 0) check({tag, "_busy_cycles"}, W'(busy_cycles), W'(v.exp_busy));
        sb.delete();
    endtask

    vec_t vecs[11];

    initial begin
        bit found;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        //          cpp cnt rnd halt inj len stl rst beats sent hlt busy
        vecs[0]  = '{4,   3,  0,  -1, -1,  0,  0,  5,  12,  3,  0,  12};
        vecs[1]  = '{4,   3,  1,  -1, -1,  0,  0, -1,  12,  3,  0,  -1};
        vecs[2]  = '{16, 100, 0,   5, -1,  0,  0, -1,  16,  1,  1,  16};
        vecs[3]  = '{4,   0,  0,  -1, -1,  0,  0, -1,   0,  0,  1,   0};
        vecs[4]  = '{4,   1,  0,  -1, -1,  0,  0, -1,   4,  1,  0,   4};
        vecs[5]  = '{8,   2,  0,  -1,  2,  1,  0, -1,  16,  2,  0,  16};
        vecs[6]  = '{8,   2,  0,  -1,  2,  3,  0, -1,  16,  2,  0,  16};
        vecs[7]  = '{8,   2,  0,  -1,  2,  3,  1, -1,  16,  2,  0,  19};
        vecs[8]  = '{0,   1,  0,  -1, -1,  0,  0, -1, 256,  1,  0, 256};
        vecs[9]  = '{4,   3,  0,   3, -1,  0,  0, -1,   4,  1,  1,   4};
        vecs[10] = '{1,   3,  0,  -1, -1,  0,  0, -1,   3,  3,  0,   3};

        reset = 1'b1;
        pg_control = 3'b000;
        cpp_in = 8'd0;
        count_in = 64'd0;
        axis_tx.tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_status", W'(pg_status), W'(0));
        check("reset_tvalid", W'(axis_tx.tvalid), W'(0));
        check("reset_tlast", W'(axis_tx.tlast), W'(0));
        check("reset_tdata", axis_tx.tdata, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-packet with a halt and an inject left pending.
        push_beats(5, 16, -1, -2);
        accepted = 0;
        @(posedge clk); #1;
        cpp_in = 8'd16;
        count_in = 64'd5;
        pg_control = 3'b001;
        found = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(posedge clk); #1;
            pg_control = 3'b000;
            if (accepted == 5) begin
                found = 1;
                break;
            end
        end
        if (!found) check("rst_wait_timeout", W'(0), W'(1));
        axis_tx.tready = 1'b0;
        pg_control = 3'b110;
        @(posedge clk); #1;
        pg_control = 3'b000;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_status", W'(pg_status), W'(0));
        check("rst_mid_tvalid", W'(axis_tx.tvalid), W'(0));
        check("rst_mid_tlast", W'(axis_tx.tlast), W'(0));
        check("rst_mid_tdata", axis_tx.tdata, '0);
        check("rst_mid_beats", W'(accepted), W'(5));
        check("rst_mid_sb_empty", W'(sb.size()), W'(0));
        sb.delete();
        axis_tx.tready = 1'b1;
        run_vec('{4, 2, 0, -1, -1, 0, 0, -1, 8, 2, 0, 8}, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
